// File: rtl/nibble_add_seq.sv
// nibble_add_seq: adds two WIDTH-bit operands over NIB = WIDTH/4 cycles. A
// single 4-bit ripple adder is shared across the nibbles, least significant
// first, and a carry register links one nibble to the next.
//
// Optional build macro: NIBBLE_ADD_SUB_EN adds a 'sub' input. When sub=1 the
// block computes a - b mod 2^WIDTH, and cout=1 means no borrow.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand request valid
//   in_ready   operands accepted (high only in IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry into nibble 0
//   sub        (NIBBLE_ADD_SUB_EN only) 1 = subtract
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   sum        registered WIDTH-bit result
//   cout       registered carry out of the top nibble
//   busy       high in RUN or DONE

module Adder4bit_using_FA (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

module nibble_add_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("nibble_add_seq: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [IW-1:0]    idx;
  logic             carry_q, cout_q;
  logic [3:0]       nib_a, nib_b, nib_s;
  logic             nib_c;
  logic             last;

  assign nib_a = a_q[4*idx +: 4];
  assign nib_b = b_q[4*idx +: 4];
  assign last  = (idx == IW'(NIB - 1));

  Adder4bit_using_FA u_add (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_c)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            idx <= '0;
`ifdef NIBBLE_ADD_SUB_EN
            // Subtraction is a + ~b + 1, so B is inverted when it is captured
            // and the initial carry is forced high.
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
`else
            b_q     <= b;
            carry_q <= cin;
`endif
          end
        end
        RUN: begin
          sum_q[4*idx +: 4] <= nib_s;
          carry_q           <= nib_c;
          idx               <= last ? '0 : idx + 1'b1;
          if (last) cout_q  <= nib_c;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq (WIDTH=16). Expected results are pushed to
// a scoreboard queue when operands are accepted, and popped when out_valid is
// seen. Build with NIBBLE_ADD_SUB_EN defined to include the subtract steps.
module tb_nibble_add_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin;
`ifdef NIBBLE_ADD_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  logic [16:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_add_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NIBBLE_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  function automatic logic [16:0] model(input logic [15:0] ma, mb,
                                        input logic mcin, msub);
    if (msub) return {1'b0, ma} + {1'b0, ~mb} + 17'd1;
    return {1'b0, ma} + {1'b0, mb} + {16'd0, mcin};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready, then lets the next edge accept the operands.
  task automatic send(input logic [15:0] ia, ib, input logic icin, isub,
                      input bit push);
    int n = 0;
    a = ia; b = ib; cin = icin;
`ifdef NIBBLE_ADD_SUB_EN
    sub = isub;
`endif
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin tick; n++; end
    chk("accept_wait", {31'd0, in_ready}, 32'd1);
    if (push) sb.push_back(model(ia, ib, icin, isub));
    tick;
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag);
    logic [16:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 'x;
    chk({tag, "_sum"},  {16'd0, sum},  {16'd0, e[15:0]});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, e[16]});
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin tick; n++; end
    chk({tag, "_valid_wait"}, {31'd0, out_valid}, 32'd1);
  endtask

  // Consumes one result with out_ready high, then passes the transfer edge.
  task automatic receive(input string tag);
    out_ready = 1'b1;
    wait_valid(tag);
    if (out_valid) begin
      check_result(tag);
      tick;
    end
  endtask

  initial begin
    logic [15:0] va[3];
    logic [15:0] vb[3];
    logic        vc[3];
    int          acc_t[3];
    int          nacc, nres;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
    sub = 1'b0;
`endif
    tick; tick;
    rst = 1'b0;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum",       {16'd0, sum},       32'd0);
    chk("rst_cout",      {31'd0, cout},      32'd0);

    // Basic add plus latency: out_valid rises exactly 4 edges after accept.
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("lat_not_valid", {31'd0, out_valid}, 32'd0);
      chk("lat_in_ready",  {31'd0, in_ready},  32'd0);
    end
    tick;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    receive("basic");
    chk("basic_in_ready_back", {31'd0, in_ready}, 32'd1);

    // Carry rippling across every nibble, and cin into nibble 0.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    receive("ripple");
    send(16'h000F, 16'h0000, 1'b1, 1'b0, 1'b1);
    receive("cin");

    // Backpressure: result held while a new request is pending.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait_valid("bp");
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_sum_hold",  {16'd0, sum},       32'h0100);
      chk("bp_valid",     {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    receive("bp");
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    sb.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
    tick;
    in_valid = 1'b0;
    chk("bp_new_busy", {31'd0, busy}, 32'd1);
    receive("bp_new");

    // Reset during the second RUN cycle discards the operation.
    send(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_sum",      {16'd0, sum},       32'd0);
    chk("abort_in_ready", {31'd0, in_ready},  32'd1);
    chk("abort_busy",     {31'd0, busy},      32'd0);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    receive("post_abort");

    // Back-to-back with in_valid and out_ready held high.
    va[0] = 16'h1111; vb[0] = 16'h2222; vc[0] = 1'b0;
    va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1'b1;
    va[2] = 16'hFFFE; vb[2] = 16'h0003; vc[2] = 1'b1;
    acc_t[0] = 0; acc_t[1] = 0; acc_t[2] = 0;
    nacc = 0; nres = 0;
    out_ready = 1'b1;
    a = va[0]; b = vb[0]; cin = vc[0]; in_valid = 1'b1;
    for (int n = 0; n < 60 && nres < 3; n++) begin
      if (in_valid && in_ready) begin
        acc_t[nacc] = cyc;
        sb.push_back(model(va[nacc], vb[nacc], vc[nacc], 1'b0));
        nacc++;
        tick;
        if (nacc < 3) begin
          a = va[nacc]; b = vb[nacc]; cin = vc[nacc];
        end else begin
          in_valid = 1'b0;
        end
      end else if (out_valid) begin
        check_result("b2b");
        nres++;
        tick;
      end else begin
        tick;
      end
    end
    chk("b2b_results", nres, 32'd3);
    chk("b2b_gap01", acc_t[1] - acc_t[0], 32'd6);
    chk("b2b_gap12", acc_t[2] - acc_t[1], 32'd6);

`ifdef NIBBLE_ADD_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    receive("sub_borrow");
    send(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1);
    receive("sub_noborrow");
    send(16'h0007, 16'h0005, 1'b1, 1'b0, 1'b1);
    receive("sub_off_add");
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
